uart_reg_responder: RTL

UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_regfile.sv | 46 ++++
 rtl/uart_reg_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART register responder:
//               FSM state encoding, default response bytes and the command
//               byte field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GET_DATA  = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Default response bytes
    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h5A;

    // Command byte field positions
    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_RSVD_MSB = 6;
    localparam int CMD_RSVD_LSB = 4;
    localparam int CMD_ADDR_MSB = 3;
    localparam int CMD_ADDR_LSB = 0;

    // Register map
    localparam int         NUM_REGS    = 15;
    localparam logic [3:0] STATUS_ADDR = 4'hF;

    // True when the reserved command bits are all zero
    function automatic logic cmd_rsvd_ok(input logic [7:0] cmd);
        return (cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == 3'b000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_regfile.sv
`default_nettype none
// ============================================================================
// Module      : uart_regfile
// Description : 15 x 8-bit register storage with one synchronous write port,
//               one combinational read port and a tap of register 0.
//               Address 0xF is not stored here; writes to it are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_regfile
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] reg0
);

    logic [7:0] regs [0:NUM_REGS-1];

    // Storage array: cleared on reset, single write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en && (wr_addr != STATUS_ADDR)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Combinational read; address 0xF returns zero (the caller muxes status)
    always_comb begin
        rd_data = 8'h00;
        if (rd_addr != STATUS_ADDR) begin
            rd_data = regs[rd_addr];
        end
    end

    assign reg0 = regs[0];

endmodule
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_responder
// Description : Byte-oriented register access protocol over a UART link.
//               A command byte selects read/write and an address; writes
//               take a following data byte (bounded by a timeout). Every
//               transaction produces exactly one response byte: read data,
//               ACK or NAK. Bytes arriving while a response is pending are
//               dropped and flagged by a sticky overrun bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_responder
    import uart_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE       = DEFAULT_NAK_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_parity_err,
    input  logic       rx_frame_err,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    input  logic       tx_done,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       overrun
);

    // Counter holds 0..TIMEOUT_CYCLES-1 and saturates at the last value
    localparam int                CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       tx_data_next;
    logic [3:0]       wr_addr;
    logic [CNT_W-1:0] cnt;

    logic             rx_err;
    logic             timeout_hit;
    logic             addr_load;
    logic             cnt_clr;
    logic             overrun_set;
    logic             rf_wr_en;
    logic [7:0]       rf_rd_data;
    logic [7:0]       read_value;

    assign rx_err      = rx_parity_err | rx_frame_err;
    assign timeout_hit = (cnt == CNT_LAST);
    assign read_value  = (rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB] == STATUS_ADDR) ? status_in : rf_rd_data;

    uart_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rf_wr_en),
        .wr_addr (wr_addr),
        .wr_data (rx_data),
        .rd_addr (rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB]),
        .rd_data (rf_rd_data),
        .reg0    (ctrl_out)
    );

    // Next-state, response selection and strobes
    always_comb begin
        state_next   = state;
        tx_data_next = tx_data;
        addr_load    = 1'b0;
        cnt_clr      = 1'b0;
        overrun_set  = 1'b0;
        rf_wr_en     = 1'b0;
        tx_send      = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_err || !cmd_rsvd_ok(rx_data)) begin
                        tx_data_next = NAK_BYTE;
                        state_next   = SEND;
                    end else if (rx_data[CMD_WR_BIT]) begin
                        addr_load    = 1'b1;
                        cnt_clr      = 1'b1;
                        state_next   = GET_DATA;
                    end else begin
                        tx_data_next = read_value;
                        state_next   = SEND;
                    end
                end
            end
            GET_DATA: begin
                // A byte arriving on the timeout cycle still counts
                if (rx_valid) begin
                    if (rx_err) begin
                        tx_data_next = NAK_BYTE;
                    end else begin
                        rf_wr_en     = 1'b1;
                        tx_data_next = ACK_BYTE;
                    end
                    state_next = SEND;
                end else if (timeout_hit) begin
                    tx_data_next = NAK_BYTE;
                    state_next   = SEND;
                end
            end
            SEND: begin
                overrun_set = rx_valid;
                if (!tx_busy) begin
                    tx_send    = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                overrun_set = rx_valid;
                if (tx_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, response byte and latched write address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx_data <= 8'h00;
            wr_addr <= 4'h0;
        end else begin
            state   <= state_next;
            tx_data <= tx_data_next;
            if (addr_load) begin
                wr_addr <= rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
            end
        end
    end

    // Timeout counter: runs only while waiting for the data byte, never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if ((state == GET_DATA) && (cnt < CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire
